// File: rtl/midi_rx.sv
// MIDI serial receiver plus channel-voice decoder.
// Drives a monophonic, last-note-priority gate with note number and velocity.
`timescale 1ns/1ps
module midi_rx #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 31250,
  parameter logic [3:0]  CHANNEL = 4'd0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] velocity,
  output logic       framing_error
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;

  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       rx_byte, rx_byte_nxt;
  logic             byte_stb, byte_stb_nxt;
  logic             framing_error_nxt;

  logic       sync_q, rx_s, rx_prev;
  logic [2:0] flush;
  logic       settled_c;

  // Synchronizer and edge history. The synchronizer resets high, so edge
  // detection waits until it has been refilled from the real line; otherwise
  // a line held low through reset would look like a fresh start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      flush   <= 3'b000;
    end else begin
      sync_q  <= midi_in;
      rx_s    <= sync_q;
      rx_prev <= rx_s;
      flush   <= {flush[1:0], 1'b1};
    end
  end

  assign settled_c = flush[2];

  // UART state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      rx_byte       <= 8'h00;
      byte_stb      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_idx_nxt;
      rx_byte       <= rx_byte_nxt;
      byte_stb      <= byte_stb_nxt;
      framing_error <= framing_error_nxt;
    end
  end

  // UART next-state: mid-bit sampling timed from the start-bit falling edge
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    bit_idx_nxt       = bit_idx;
    rx_byte_nxt       = rx_byte;
    byte_stb_nxt      = 1'b0;
    framing_error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (settled_c && rx_prev && !rx_s) begin
          state_nxt   = START;
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          rx_byte_nxt = {rx_s, rx_byte[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_stb_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            framing_error_nxt = 1'b1;
            state_nxt         = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic       st_active, st_on, data_idx;
  logic [6:0] note_tmp;
  logic       is_realtime_c, is_system_c, note_class_c, chan_ok_c;

  assign is_realtime_c = (rx_byte[7:3] == 5'b11111);
  assign is_system_c   = (rx_byte[7:4] == 4'hF);
  assign note_class_c  = (rx_byte[7:5] == 3'b100);
  assign chan_ok_c     = OMNI || (rx_byte[3:0] == CHANNEL);

  // Running-status parser; realtime bytes pass through without touching state
  always_ff @(posedge clk) begin
    if (rst) begin
      st_active  <= 1'b0;
      st_on      <= 1'b0;
      data_idx   <= 1'b0;
      note_tmp   <= 7'd0;
      midi_data  <= 8'h00;
      velocity   <= 8'h00;
      midi_valid <= 1'b0;
    end else if (byte_stb && !is_realtime_c) begin
      if (is_system_c) begin
        st_active <= 1'b0;
      end else if (rx_byte[7]) begin
        st_active <= note_class_c && chan_ok_c;
        st_on     <= rx_byte[4];
        data_idx  <= 1'b0;
      end else if (st_active) begin
        if (!data_idx) begin
          note_tmp <= rx_byte[6:0];
          data_idx <= 1'b1;
        end else begin
          data_idx <= 1'b0;
          if (st_on && (rx_byte[6:0] != 7'd0)) begin
            midi_data  <= {1'b0, note_tmp};
            velocity   <= {1'b0, rx_byte[6:0]};
            midi_valid <= 1'b1;
          end else if (midi_valid && (note_tmp == midi_data[6:0])) begin
            midi_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// Bench for midi_rx: byte-vector table with scoreboard, two instances
// (single channel and omni) fed from the same serial line.
`timescale 1ns/1ps
module tb_midi_rx;

  localparam int unsigned CLK_HZ = 500000;
  localparam int unsigned BAUD   = 31250;
  localparam int unsigned CPB    = CLK_HZ / BAUD;

  typedef struct {
    logic [7:0] b;
    logic       bad;
    logic [7:0] d;
    logic       v;
    logic [7:0] vel;
    logic [7:0] od;
    logic       ov;
    logic [7:0] ovel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       midi_in;
  logic [7:0] d_data, d_vel, o_data, o_vel;
  logic       d_valid, o_valid, d_fe, o_fe;

  int checks   = 0;
  int failures = 0;
  int fe_total_d = 0;
  int fe_total_o = 0;

  vec_t vecs[$];
  vec_t sb_q[$];
  vec_t prev;
  vec_t zero_v;

  always #5 clk = ~clk;

  midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(4'd0), .OMNI(1'b0)) u_dut (
    .clk(clk), .rst(rst), .midi_in(midi_in),
    .midi_data(d_data), .midi_valid(d_valid), .velocity(d_vel), .framing_error(d_fe)
  );

  midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(4'd0), .OMNI(1'b1)) u_omni (
    .clk(clk), .rst(rst), .midi_in(midi_in),
    .midi_data(o_data), .midi_valid(o_valid), .velocity(o_vel), .framing_error(o_fe)
  );

  // framing_error high-cycle totals, sampled away from the active edge
  always @(negedge clk) begin
    if (d_fe) fe_total_d++;
    if (o_fe) fe_total_o++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [7:0] b, input logic bad,
                              input logic [7:0] d, input logic v, input logic [7:0] vel,
                              input logic [7:0] od, input logic ov, input logic [7:0] ovel);
    vec_t r;
    r.b = b; r.bad = bad; r.d = d; r.v = v; r.vel = vel;
    r.od = od; r.ov = ov; r.ovel = ovel;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int idx, input vec_t e);
    chk({tag, "_data"},       idx, 32'(d_data),  32'(e.d));
    chk({tag, "_valid"},      idx, 32'(d_valid), 32'(e.v));
    chk({tag, "_vel"},        idx, 32'(d_vel),   32'(e.vel));
    chk({tag, "_omni_data"},  idx, 32'(o_data),  32'(e.od));
    chk({tag, "_omni_valid"}, idx, 32'(o_valid), 32'(e.ov));
    chk({tag, "_omni_vel"},   idx, 32'(o_vel),   32'(e.ovel));
  endtask

  task automatic drive_bit(input logic val, input int cycles);
    midi_in = val;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input vec_t v, input int idx);
    int fe_d0;
    int fe_o0;
    vec_t got;
    fe_d0 = fe_total_d;
    fe_o0 = fe_total_o;
    sb_q.push_back(v);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(v.b[i], CPB);
    chk_outs("early", idx, prev);
    drive_bit(!v.bad, CPB);
    got = sb_q.pop_front();
    chk_outs("final", idx, got);
    chk("fe_pulses", idx, 32'(fe_total_d - fe_d0), 32'(got.bad));
    chk("fe_pulses_omni", idx, 32'(fe_total_o - fe_o0), 32'(got.bad));
    prev = got;
    if (v.bad) drive_bit(1'b1, CPB);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(vecs[i], i);
  endtask

  initial begin
    int fe_d0;
    int fe_o0;
    logic [7:0] rb;

    zero_v = mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    prev   = zero_v;

    // note-on, running status, last-note priority, release
    vecs.push_back(mk(8'h90, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00));
    vecs.push_back(mk(8'h3C, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00));
    vecs.push_back(mk(8'h64, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h3E, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h50, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h80, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h3C, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h40, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h90, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h3E, 0, 8'h3E, 1, 8'h50, 8'h3E, 1, 8'h50));
    vecs.push_back(mk(8'h00, 0, 8'h3E, 0, 8'h50, 8'h3E, 0, 8'h50));
    // channel 1: only the omni instance responds
    vecs.push_back(mk(8'h91, 0, 8'h3E, 0, 8'h50, 8'h3E, 0, 8'h50));
    vecs.push_back(mk(8'h40, 0, 8'h3E, 0, 8'h50, 8'h3E, 0, 8'h50));
    vecs.push_back(mk(8'h7F, 0, 8'h3E, 0, 8'h50, 8'h40, 1, 8'h7F));
    // realtime between data bytes, then sysex clears status
    vecs.push_back(mk(8'h90, 0, 8'h3E, 0, 8'h50, 8'h40, 1, 8'h7F));
    vecs.push_back(mk(8'h3C, 0, 8'h3E, 0, 8'h50, 8'h40, 1, 8'h7F));
    vecs.push_back(mk(8'hF8, 0, 8'h3E, 0, 8'h50, 8'h40, 1, 8'h7F));
    vecs.push_back(mk(8'h64, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'hF0, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h3E, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h50, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h80, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h3C, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    vecs.push_back(mk(8'h00, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    // framing error on a status byte: following data ignored
    vecs.push_back(mk(8'hF0, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    vecs.push_back(mk(8'h90, 1, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    vecs.push_back(mk(8'h3C, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    vecs.push_back(mk(8'h64, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    // 28..30: note held before mid-byte reset
    vecs.push_back(mk(8'h90, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    vecs.push_back(mk(8'h3C, 0, 8'h3C, 0, 8'h64, 8'h3C, 0, 8'h64));
    vecs.push_back(mk(8'h64, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));
    // 31..33: decode after reset
    vecs.push_back(mk(8'h90, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00));
    vecs.push_back(mk(8'h3C, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00));
    vecs.push_back(mk(8'h64, 0, 8'h3C, 1, 8'h64, 8'h3C, 1, 8'h64));

    rst     = 1'b1;
    midi_in = 1'b1;
    repeat (4) @(negedge clk);
    chk_outs("reset", -1, zero_v);
    chk("reset_fe", -1, 32'(d_fe), 32'd0);
    chk("reset_fe_omni", -1, 32'(o_fe), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    run_vecs(0, 27);

    // short low glitch on an idle line
    fe_d0 = fe_total_d;
    fe_o0 = fe_total_o;
    midi_in = 1'b0;
    repeat (5) @(negedge clk);
    midi_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk_outs("glitch", -1, prev);
    chk("glitch_fe", -1, 32'(fe_total_d - fe_d0), 32'd0);
    chk("glitch_fe_omni", -1, 32'(fe_total_o - fe_o0), 32'd0);

    run_vecs(28, 30);

    // reset in the middle of data bit 4 of 0x3C
    rb = 8'h3C;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(rb[i], CPB);
    midi_in = rb[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outs("midrst", -1, zero_v);
    chk("midrst_fe", -1, 32'(d_fe), 32'd0);
    chk("midrst_fe_omni", -1, 32'(o_fe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fe_d0 = fe_total_d;
    fe_o0 = fe_total_o;
    repeat (CPB - CPB / 2 - 2) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(rb[i], CPB);
    drive_bit(1'b1, 12 * CPB);
    chk_outs("postrst", -1, zero_v);
    chk("postrst_fe", -1, 32'(fe_total_d - fe_d0), 32'd0);
    chk("postrst_fe_omni", -1, 32'(fe_total_o - fe_o0), 32'd0);
    prev = zero_v;

    run_vecs(31, 33);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_rx.md
# midi_rx

Serial MIDI receiver and channel-voice decoder that produces the `midi_data` / `midi_valid` / velocity stream consumed by the instrument/voice blocks. It converts the opto-isolated 31250 baud MIDI line into a monophonic last-note-held gate: the note number on `midi_data` and a level gate on `midi_valid`. It sits between the board MIDI input pin and the instrument's `midi_data`, `midi_valid` and `amplitude` inputs.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `BAUD`, 31250, serial bit rate; `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division (1600 at defaults).
- `CHANNEL`, 4'd0, MIDI channel accepted when `OMNI = 0`.
- `OMNI`, 1'b0, 1 = accept note messages on all 16 channels.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `midi_in`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `midi_data`  out  8  note number of the held note; `[7]` always 0.
- `midi_valid`  out  1  gate; high while a note is held.
- `velocity`  out  8  note-on velocity of the held note; `[7]` always 0.
- `framing_error`  out  1  one-cycle pulse when a byte's stop bit samples low.

## Operation
- `midi_in` passes through a 2-flop synchronizer. All bit logic uses the synchronized signal `rx_s`.

UART FSM:
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a falling edge on `rx_s` goes to START and clears the bit counter.
- START: waits `CLKS_PER_BIT/2` cycles, then samples `rx_s`. Low goes to DATA; high means a glitch and returns to IDLE with no error.
- DATA: samples every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shifted into `rx_byte`.
- STOP: samples after `CLKS_PER_BIT` cycles.
  - High: issues an internal one-cycle `byte_stb` and goes to IDLE.
  - Low: pulses `framing_error`, discards the byte and goes to WAIT_HIGH.
- WAIT_HIGH: returns to IDLE when `rx_s` = 1.

Parser, advanced on `byte_stb`:
- 0xF8–0xFF (realtime): ignored completely. Running status and the data-byte index are untouched, including between two data bytes.
- 0xF0–0xF7: clears running status. Following data bytes are ignored.
- 0x80–0xEF: sets running status to the byte and clears the data index.
  - Note class (0x8n or 0x9n) with accepted channel: status is "active" (n = `CHANNEL`, or any n when `OMNI`).
  - Other classes or channels: status is "inactive".
- Data byte (bit 7 = 0):
  - Ignored if running status is cleared or inactive.
  - Otherwise index 0 latches `note_tmp` and sets index 1.
  - Index 1 executes the message and returns index to 0, so running status allows repeated pairs.
- Execute:
  - Note-on (0x9n) with velocity ≠ 0: `midi_data` ← `note_tmp`, `velocity` ← velocity byte, `midi_valid` ← 1. This is last-note priority and replaces any held note.
  - Note-off (0x8n), or 0x9n with velocity 0: if `midi_valid` = 1 and `note_tmp` = `midi_data`, then `midi_valid` ← 0. Otherwise no change.
  - `midi_data` and `velocity` hold their values after the gate drops.

## Timing
- Reset:
  - `midi_data` = 0, `velocity` = 0, `midi_valid` = 0, `framing_error` = 0.
  - UART in IDLE; running status cleared; data index 0; synchronizer flops = 1.
- `rst` mid-byte aborts the byte with no output or error. If the line is still low afterwards, no start is detected until a high-to-low edge occurs.
- Bit sample k (k = 0 start, 1–8 data, 9 stop) occurs at (k + 0.5)·`CLKS_PER_BIT` cycles after `rx_s` falls, ±1 cycle. `rx_s` lags `midi_in` by 2 cycles.
- `byte_stb` is asserted in the cycle after the stop sample.
- Outputs update in the cycle after `byte_stb`, i.e. 2 cycles after the stop sample.
- `framing_error` is asserted in the cycle after a low stop sample, for exactly 1 cycle.
- Byte-to-byte throughput: back-to-back bytes with no idle gap are received without loss.

## Test plan
- Note-on: send 0x90, 0x3C, 0x64 (CHANNEL = 0) -> `midi_data` = 0x3C, `velocity` = 0x64, `midi_valid` = 1, 2 cycles after the third stop sample.
- Running status and last-note priority: after the note-on above, send 0x3E, 0x50 -> `midi_data` = 0x3E, `velocity` = 0x50. Then send 0x80, 0x3C, 0x40 -> `midi_valid` stays 1. Then 0x90, 0x3E, 0x00 -> `midi_valid` = 0, `midi_data` stays 0x3E.
- Channel filter: with OMNI = 0, send 0x91, 0x40, 0x7F -> no output change. With OMNI = 1, the same bytes -> `midi_data` = 0x40, `midi_valid` = 1.
- Realtime interleave and status clear:
  - Send 0x90, 0x3C, 0xF8, 0x64 -> note-on 0x3C with velocity 0x64.
  - Then send 0xF0, 0x3E, 0x50 -> no change.
- Framing error and glitch:
  - Send 0x90 with a low stop bit -> one-cycle `framing_error`; following 0x3C, 0x64 ignored (no running status).
  - A 100-cycle low pulse on idle line -> no byte, no error.
- Reset mid-byte: assert `rst` during data bit 4 of 0x3C while a note is held -> all outputs 0 the next cycle. The next complete 0x90, 0x3C, 0x64 decodes correctly.
